// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI serial-clock generator.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, TRAIL} spi_sck_state_t;

  localparam int SPI_DIV_W = 8;
  localparam int SPI_CNT_W = 6;

  localparam logic SPI_CPHA0 = 1'b0;
  localparam logic SPI_CPHA1 = 1'b1;
endpackage

// File: rtl/spi_half_tick.sv
// Loadable half-period counter: ticks for one cycle when hc reaches div.
module spi_half_tick #(
  parameter int DIV_W = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] hc;

  assign tick = en && (hc == div);

  // hc never exceeds div, so it cannot wrap early even at the maximum divide.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       hc <= '0;
    else if (clr)    hc <= '0;
    else if (tick)   hc <= '0;
    else if (en)     hc <= hc + 1'b1;
  end
endmodule

// File: rtl/spi_sck_gen.sv
// SPI sck generator: programmable half-period, CPOL/CPHA, N-bit bursts,
// launch/sample strobes, done/busy handshake and abort.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int   DIV_W    = SPI_DIV_W,
  parameter int   CNT_W    = SPI_CNT_W,
  parameter logic CPOL_RST = 1'b0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic             abort,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] nbits,
  output logic             sck,
  output logic             busy,
  output logic             launch_stb,
  output logic             sample_stb,
  output logic             done
);
  spi_sck_state_t   state, state_n;
  logic             cpol_l, cpha_l;
  logic [DIV_W-1:0] div_l;
  logic [CNT_W-1:0] nbits_l;
  logic [CNT_W:0]   edge_cnt, edge_n, k;
  logic             sck_n, busy_n, launch_n, sample_n, done_n;
  logic             accept, kill, hc_clr, tick, last;

  spi_half_tick #(.DIV_W(DIV_W)) u_tick (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (hc_clr),
    .en   (state != IDLE),
    .div  (div_l),
    .tick (tick)
  );

  assign k    = edge_cnt + {{CNT_W{1'b0}}, 1'b1};
  assign last = (k == {nbits_l, 1'b0});

  always_comb begin
    state_n  = state;
    sck_n    = sck;
    busy_n   = busy;
    launch_n = 1'b0;
    sample_n = 1'b0;
    done_n   = 1'b0;
    edge_n   = edge_cnt;
    accept   = 1'b0;
    kill     = 1'b0;
    hc_clr   = 1'b0;

    case (state)
      IDLE: begin
        sck_n  = cpol;
        accept = start;
      end
      ACTIVE: begin
        if (abort) kill = 1'b1;
        else if (tick) begin
          edge_n = k;
          sck_n  = ~sck;
          // k[0]=1 is the leading edge of a bit
          if (k[0]) begin
            if (cpha_l == SPI_CPHA0) sample_n = 1'b1;
            else                     launch_n = 1'b1;
          end else begin
            if (cpha_l == SPI_CPHA1) sample_n = 1'b1;
            else                     launch_n = !last;
          end
          if (last) begin
            sck_n   = cpol_l;
            state_n = TRAIL;
            edge_n  = '0;
          end
        end
      end
      TRAIL: begin
        if (abort) kill = 1'b1;
        else if (tick) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
          sck_n   = cpol_l;
          accept  = start;
        end
      end
      default: state_n = IDLE;
    endcase

    if (kill) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      sck_n   = cpol_l;
      edge_n  = '0;
      hc_clr  = 1'b1;
    end

    // An empty burst has nothing to pre-launch.
    if (accept) begin
      busy_n   = 1'b1;
      sck_n    = cpol;
      edge_n   = '0;
      hc_clr   = 1'b1;
      state_n  = (nbits == '0) ? TRAIL : ACTIVE;
      launch_n = (cpha == SPI_CPHA0) && (nbits != '0);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      sck        <= CPOL_RST;
      busy       <= 1'b0;
      launch_stb <= 1'b0;
      sample_stb <= 1'b0;
      done       <= 1'b0;
      edge_cnt   <= '0;
      cpol_l     <= 1'b0;
      cpha_l     <= 1'b0;
      div_l      <= '0;
      nbits_l    <= '0;
    end else begin
      state      <= state_n;
      sck        <= sck_n;
      busy       <= busy_n;
      launch_stb <= launch_n;
      sample_stb <= sample_n;
      done       <= done_n;
      edge_cnt   <= edge_n;
      if (accept) begin
        cpol_l  <= cpol;
        cpha_l  <= cpha;
        div_l   <= div;
        nbits_l <= nbits;
      end
    end
  end
endmodule

// File: tb/tb_spi_sck_gen.sv
// Directed bench for spi_sck_gen; values checked #1 after each posedge.
module tb_spi_sck_gen;
  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       start = 1'b0, abort = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [7:0] div = '0;
  logic [5:0] nbits = '0;
  logic       sck, busy, launch_stb, sample_stb, done;
  int         checks = 0, errors = 0;

  spi_sck_gen #(.DIV_W(8), .CNT_W(6), .CPOL_RST(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .abort(abort), .cpol(cpol),
    .cpha(cpha), .div(div), .nbits(nbits), .sck(sck), .busy(busy),
    .launch_stb(launch_stb), .sample_stb(sample_stb), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic tk();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int nedge, nl, ns, nd, dc, bad;
    logic prev;

    // reset state
    #12;
    chk("rst_sck", sck, 1);
    chk("rst_busy", busy, 0);
    chk("rst_stb", {launch_stb, sample_stb, done}, 0);
    nRST = 1'b1;
    tk();
    chk("idle_sck_follows_cpol", sck, 0);

    // div=0 nbits=2 cpol=0 cpha=0
    div = 0; nbits = 2; cpol = 0; cpha = 0; start = 1;
    tk(); start = 0;
    chk("t1_e0_busy", busy, 1);
    chk("t1_e0_launch", launch_stb, 1);
    tk(); chk("t1_e1", {sck, launch_stb, sample_stb}, 3'b101);
    tk(); chk("t1_e2", {sck, launch_stb, sample_stb}, 3'b010);
    tk(); chk("t1_e3", {sck, launch_stb, sample_stb}, 3'b101);
    tk(); chk("t1_e4", {sck, launch_stb, sample_stb, busy, done}, 5'b00010);
    tk(); chk("t1_e5", {busy, done}, 2'b01);
    tk(); chk("t1_e6", {busy, done}, 2'b00);

    // div=3 nbits=8 cpol=1 cpha=1
    cpol = 1; cpha = 1; div = 3; nbits = 8;
    tk(); tk();
    chk("t2_idle_sck", sck, 1);
    start = 1;
    tk(); start = 0;
    nedge = 0; nl = 0; ns = 0; nd = 0; dc = 0; bad = 0; prev = sck;
    for (int c = 1; c <= 68; c++) begin
      tk();
      if (sck !== prev) begin
        nedge++;
        if (c != 4 * nedge) bad++;
      end
      prev = sck;
      if (launch_stb) begin nl++; if (sck !== 1'b0) bad++; end
      if (sample_stb) begin ns++; if (sck !== 1'b1) bad++; end
      if (launch_stb && sample_stb) bad++;
      if (done) begin nd++; dc = c; end
      if (c > 64 && sck !== 1'b1) bad++;
    end
    chk("t2_edges", nedge, 16);
    chk("t2_launch", nl, 8);
    chk("t2_sample", ns, 8);
    chk("t2_bad", bad, 0);
    chk("t2_done_cnt", nd, 1);
    chk("t2_done_cyc", dc, 68);
    chk("t2_busy_end", busy, 0);

    // abort after 5th edge: div=1 nbits=4 cpol=0 cpha=0
    cpol = 0; cpha = 0; div = 1; nbits = 4;
    tk();
    start = 1; tk(); start = 0;
    repeat (10) tk();
    chk("t3_e10_sck", {sck, busy}, 2'b11);
    abort = 1; tk(); abort = 0;
    chk("t3_abort", {sck, busy, launch_stb, sample_stb, done}, 5'b00000);
    start = 1; tk(); start = 0;
    chk("t3_restart", {busy, launch_stb}, 2'b11);
    nedge = 0; nd = 0; dc = 0; prev = sck;
    for (int c = 1; c <= 18; c++) begin
      tk();
      if (sck !== prev) nedge++;
      prev = sck;
      if (done) begin nd++; dc = c; end
    end
    chk("t3_edges", nedge, 8);
    chk("t3_done_cnt", nd, 1);
    chk("t3_done_cyc", dc, 18);

    // nbits=0 div=2, start held into the busy window
    tk();
    nbits = 0; div = 2; cpha = 1;
    start = 1; tk();
    nl = 0; ns = 0; bad = 0;
    tk(); start = 0;
    chk("t4_busy_e1", busy, 1);
    if (launch_stb || sample_stb) nl++;
    if (sck !== 1'b0) bad++;
    tk();
    chk("t4_busy_e2", {busy, done}, 2'b10);
    if (launch_stb || sample_stb) nl++;
    if (sck !== 1'b0) bad++;
    tk();
    chk("t4_done_e3", {busy, done}, 2'b01);
    if (launch_stb || sample_stb) nl++;
    chk("t4_no_strobes", nl, 0);
    chk("t4_no_edges", bad, 0);
    tk();
    chk("t4_idle_e4", {busy, done}, 2'b00);

    // back-to-back: nbits=1 div=0, start held
    nbits = 1; div = 0; cpol = 0; cpha = 0;
    start = 1; tk();
    chk("t5_e0", {sck, busy, launch_stb}, 3'b011);
    tk(); chk("t5_e1", {sck, sample_stb}, 2'b11);
    cpol = 1;
    tk(); chk("t5_e2_cpol_ignored", {sck, launch_stb, done}, 3'b000);
    cpol = 0;
    tk(); chk("t5_e3", {done, busy, launch_stb, sck}, 4'b1110);
    tk(); chk("t5_e4", {sck, sample_stb, done}, 3'b110);
    tk(); chk("t5_e5", {sck, done}, 2'b00);
    start = 0;
    tk(); chk("t5_e6", {done, busy}, 2'b10);
    tk(); chk("t5_idle", busy, 0);

    // reset mid-burst
    div = 3; nbits = 4; cpol = 0; cpha = 0;
    start = 1; tk(); start = 0;
    repeat (8) tk();
    chk("t6_pre", {sck, launch_stb, busy}, 3'b011);
    nRST = 0; #1;
    chk("t6_rst", {sck, busy, launch_stb, sample_stb, done}, 5'b10000);
    tk(); tk();
    nRST = 1; #2;
    chk("t6_hold", sck, 1);
    @(posedge CLK); #1;
    chk("t6_follow", {sck, busy}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
